// File: rtl/shift_add_mul_ctrl.sv
// -----------------------------------------------------------------------------
// shift_add_mul_ctrl
//
// Purpose:
//   Sequential 16x16 -> 32 unsigned multiplier using the shift-and-add method.
//   One partial product is accumulated per RUN cycle through a single 32-bit
//   carry-lookahead adder (adder32). The result is registered on P and held
//   until the next operation completes.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   synchronous active-low reset
//   start  in   1   request a multiply; sampled only in IDLE or DONE
//   A      in   16  multiplicand, unsigned
//   B      in   16  multiplier, unsigned
//   busy   out  1   high while an operation is in RUN
//   done   out  1   one-cycle pulse; P valid in this cycle
//   P      out  32  product, registered
//
// Configuration macro:
//   EARLY_TERM_EN  when defined, RUN ends as soon as the remaining multiplier
//                  bits are all zero (minimum one iteration). Results are
//                  identical either way; only latency changes.
//
// Also contains adder32, the 32-bit carry-lookahead adder (4-bit lookahead
// groups chained through group generate/propagate).
// -----------------------------------------------------------------------------

module adder32 (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_cin,
   output logic [31:0] o_sum,
   output logic        o_c32
);

   // Carry into each 4-bit group; w_gc[8] is the carry out of bit 31.
   logic [8:0] w_gc;
   logic [7:0] w_grp_g;
   logic [7:0] w_grp_p;

   assign w_gc[0] = i_cin;

   for (genvar k = 0; k < 8; k++) begin : g_nib
      logic [3:0] w_g;
      logic [3:0] w_p;
      logic [3:0] w_c;

      assign w_g = i_a[4*k +: 4] & i_b[4*k +: 4];
      assign w_p = i_a[4*k +: 4] ^ i_b[4*k +: 4];

      // Bit carries inside the group, all derived directly from the group carry-in.
      assign w_c[0] = w_gc[k];
      assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
      assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
      assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                    | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);

      assign w_grp_g[k] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                        | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
      assign w_grp_p[k] = &w_p;

      assign o_sum[4*k +: 4] = w_p ^ w_c;
      assign w_gc[k+1]       = w_grp_g[k] | (w_grp_p[k] & w_gc[k]);
   end

   assign o_c32 = w_gc[8];

endmodule

module shift_add_mul_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] P
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]  r_state;
   logic [31:0] r_acc;
   logic [31:0] r_mcand;
   logic [15:0] r_mult;
   logic [3:0]  r_cnt;
   logic [31:0] r_p;

   logic [1:0]  w_state_nxt;
   logic [31:0] w_acc_nxt;
   logic [31:0] w_mcand_nxt;
   logic [15:0] w_mult_nxt;
   logic [3:0]  w_cnt_nxt;
   logic [31:0] w_p_nxt;

   logic [31:0] w_sum;
   // The full product fits in 32 bits, so the adder carry-out is never needed.
   logic        w_c32_unused;
   logic        w_last;

   adder32 u_adder (
      .i_a   (r_acc),
      .i_b   (r_mcand),
      .i_cin (1'b0),
      .o_sum (w_sum),
      .o_c32 (w_c32_unused)
   );

`ifdef EARLY_TERM_EN
   // Stop once the bits still to be shifted out are all zero; the cnt term is
   // redundant (after 15 shifts only bit 0 can remain) but keeps the bound explicit.
   assign w_last = (r_cnt == 4'd15) | (r_mult[15:1] == 15'd0);
`else
   assign w_last = (r_cnt == 4'd15);
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_mcand_nxt = r_mcand;
      w_mult_nxt  = r_mult;
      w_cnt_nxt   = r_cnt;
      w_p_nxt     = r_p;

      case (r_state)
         StIdle, StDone: begin
            if (start) begin
               w_state_nxt = StRun;
               w_mcand_nxt = {16'b0, A};
               w_mult_nxt  = B;
               w_acc_nxt   = 32'd0;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_state_nxt = StIdle;
            end
         end
         StRun: begin
            w_acc_nxt   = r_mult[0] ? w_sum : r_acc;
            w_mcand_nxt = r_mcand << 1;
            w_mult_nxt  = r_mult >> 1;
            w_cnt_nxt   = r_cnt + 4'd1;
            if (w_last) begin
               // Capture includes this iteration's add.
               w_p_nxt     = w_acc_nxt;
               w_state_nxt = StDone;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_acc   <= 32'd0;
         r_mcand <= 32'd0;
         r_mult  <= 16'd0;
         r_cnt   <= 4'd0;
         r_p     <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_mcand <= w_mcand_nxt;
         r_mult  <= w_mult_nxt;
         r_cnt   <= w_cnt_nxt;
         r_p     <= w_p_nxt;
      end
   end

   assign busy = (r_state == StRun);
   assign done = (r_state == StDone);
   assign P    = r_p;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_add_mul_ctrl
//
// Self-checking bench for shift_add_mul_ctrl. Expected products are pushed to a
// queue when an operation is issued and popped when done is seen. Latency and
// busy duration are derived from B (honours EARLY_TERM_EN when defined).
// -----------------------------------------------------------------------------

module tb_shift_add_mul_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic        busy;
   logic        done;
   logic [31:0] P;

   logic [31:0] q_exp[$];
   logic [31:0] last_p;
   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;

   shift_add_mul_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .P     (P)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Cycles from the start-sampling edge to the negedge where done is seen.
   function automatic int exp_lat(input logic [15:0] b);
      int msb_iters;
      int iters;
      msb_iters = 1;
      for (int i = 0; i < 16; i++) if (b[i]) msb_iters = i + 1;
`ifdef EARLY_TERM_EN
      iters = msb_iters;
`else
      iters = (msb_iters > 0) ? 16 : 16;
`endif
      return iters + 1;
   endfunction

   // Scoreboard side: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      logic [31:0] exp_p;
      if (busy) chk("c32_zero", {31'b0, dut.w_c32_unused}, 32'd0);
      if (done) begin
         if (q_exp.size() == 0) begin
            chk("spurious_done", {31'b0, done}, 32'd0);
         end else begin
            exp_p = q_exp.pop_front();
            chk("product", P, exp_p);
            last_p = exp_p;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Called at a negedge: drive a request that the next posedge samples.
   task automatic issue(input logic [15:0] a, input logic [15:0] b);
      A     = a;
      B     = b;
      start = 1'b1;
      q_exp.push_back(32'(a) * 32'(b));
   endtask

   task automatic wait_done(input logic [15:0] b);
      int n;
      int nb;
      n  = 1;
      nb = 0;
      @(negedge clk);
      start = 1'b0;
      // Input changes after acceptance must not disturb the operation.
      A = 16'($urandom);
      B = 16'($urandom);
      chk("p_hold", P, last_p);
      while (!done && n < 40) begin
         if (busy) nb++;
         @(negedge clk);
         n++;
      end
      chk("latency", 32'(n), 32'(exp_lat(b)));
      chk("busy_cycles", 32'(nb), 32'(exp_lat(b) - 1));
   endtask

   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit pulse_chk);
      issue(a, b);
      wait_done(b);
      if (pulse_chk) begin
         @(negedge clk);
         chk("done_pulse", {31'b0, done}, 32'd0);
      end
   endtask

   initial begin
      int ndone;
      rst_n  = 1'b0;
      start  = 1'b1;
      A      = 16'h1111;
      B      = 16'h2222;
      last_p = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_p", P, 32'd0);

      // First start accepted at the first edge with rst_n high.
      rst_n = 1'b1;
      issue(16'h0003, 16'h0005);
      wait_done(16'h0005);
      chk("p_3x5", P, 32'h0000_000F);
      @(negedge clk);
      chk("done_pulse", {31'b0, done}, 32'd0);

      do_op(16'hFFFF, 16'hFFFF, 1'b1);
      chk("p_ffff", P, 32'hFFFE_0001);

      // Back-to-back with start held in the DONE cycle.
      issue(16'd2, 16'd7);
      wait_done(16'd7);
      chk("p_b2b_first", P, 32'd14);
      issue(16'd10, 16'd10);
      wait_done(16'd10);
      chk("p_b2b_second", P, 32'd100);
      @(negedge clk);
      chk("done_pulse", {31'b0, done}, 32'd0);

      // start during RUN is ignored.
      issue(16'd6, 16'd9);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      A     = 16'hFFFF;
      B     = 16'hFFFF;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("ignore_start_pulses", 32'(ndone), 32'd1);
      chk("p_6x9", P, 32'd54);

      // Early-termination boundary patterns (latency follows the build).
      do_op(16'hABCD, 16'h0001, 1'b1);
      chk("p_abcd", P, 32'h0000_ABCD);
      do_op(16'h1234, 16'h0000, 1'b1);
      chk("p_zero", P, 32'd0);
      do_op(16'h0007, 16'h8000, 1'b1);
      chk("p_8000", P, 32'h0003_8000);

      for (int i = 0; i < 4; i++) begin
         do_op(16'($urandom), 16'($urandom), 1'b1);
      end

      // Reset in the middle of RUN discards the operation.
      A     = 16'h1234;
      B     = 16'h1234;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rrun_busy", {31'b0, busy}, 32'd0);
      chk("rrun_done", {31'b0, done}, 32'd0);
      chk("rrun_p", P, 32'd0);
      rst_n  = 1'b1;
      last_p = 32'd0;
      ndone  = 0;
      repeat (25) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("rrun_no_done", 32'(ndone), 32'd0);
      do_op(16'h1234, 16'h1234, 1'b1);
      chk("p_1234sq", P, 32'h014B_5A90);

      // Reset while in DONE clears done on the next cycle.
      issue(16'd100, 16'd200);
      wait_done(16'd200);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rdone_done", {31'b0, done}, 32'd0);
      chk("rdone_p", P, 32'd0);
      rst_n  = 1'b1;
      last_p = 32'd0;
      repeat (3) @(negedge clk);

      chk("queue_empty", 32'(q_exp.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/shift_add_mul_ctrl.md
SHIFT_ADD_MUL_CTRL -- requirements
Module: shift_add_mul_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Port list, in order:
- clk    input   1   rising-edge clock
- rst_n  input   1   synchronous active-low reset
- start  input   1   request a multiply; sampled only in IDLE or DONE
- A      input   16  multiplicand, unsigned
- B      input   16  multiplier, unsigned
- busy   output  1   high while an operation is in RUN
- done   output  1   one-cycle pulse; P valid in this cycle
- P      output  32  product, registered, holds until the next done
REQ-003 All accumulation SHALL go through one instance of the team's 32-bit carry-lookahead adder (adder32), with inputs acc and mcand.
REQ-004 Carry-in SHALL be 0 and adder C32 SHALL be ignored.

Function
REQ-005 States SHALL be IDLE, RUN and DONE.
REQ-006 busy SHALL be 1 exactly when the state is RUN.
REQ-007 done SHALL be 1 exactly when the state is DONE.
REQ-008 IDLE or DONE with start=1 at an edge:
- mcand <= {16'b0, A}
- mult <= B
- acc <= 0
- cnt <= 0
- state -> RUN
REQ-009 IDLE with start=0 SHALL stay IDLE; DONE with start=0 SHALL go to IDLE.
REQ-010 Each RUN edge SHALL do one iteration:
- acc <= acc + mcand if mult[0]=1, else acc unchanged
- mcand <= mcand << 1
- mult <= mult >> 1
- cnt <= cnt + 1
REQ-011 The edge that completes iteration 16 (cnt=15) SHALL:
- load P with the final acc value (including that iteration's add)
- move state to DONE
REQ-012 Latency: start sampled at edge E0 -> done high in the cycle after edge E16.
REQ-013 Back-to-back throughput is one result per 17 cycles when start is held in DONE.
REQ-014 start in RUN SHALL be ignored; changes to A/B after E0 SHALL NOT affect the result.
REQ-015 The product SHALL equal A*B modulo 2^32.
REQ-016 The exact product fits 32 bits, so adder C32 is always 0; the bench asserts this.
REQ-017 P SHALL change only at the edge entering DONE, or at reset.

Reset
REQ-018 An edge with rst_n=0 SHALL force the following, overriding start and any in-flight state:
- state=IDLE
- busy=0, done=0, P=0
- acc=0, mcand=0, mult=0, cnt=0
REQ-019 Reset during RUN SHALL discard the operation, with no done pulse afterwards.
REQ-020 Reset during DONE SHALL clear done in the next cycle.
REQ-021 The first start SHALL be accepted at the first edge with rst_n=1.

Configuration
REQ-022 Macro EARLY_TERM_EN, when defined, SHALL end RUN at the edge where the shifted-out multiplier becomes zero:
- iteration count = max(1, index of the highest set bit of B + 1)
- B=0 -> one iteration, P=0
- done follows the final iteration edge by one cycle
REQ-023 Without EARLY_TERM_EN, RUN SHALL always take exactly 16 iterations, whatever the value of B.
REQ-024 Results SHALL be identical with and without the macro; only latency differs.

Verification
REQ-025 A=0x0003, B=0x0005, start at E0 -> busy for 16 cycles, done high in the cycle after E16, P=0x0000000F.
REQ-026 A=0xFFFF, B=0xFFFF -> P=0xFFFE0001; C32 stays 0 on every RUN edge.
REQ-027 Back-to-back: A=2, B=7, then start held in the DONE cycle with A=10, B=10 -> P=14, then P=100 exactly 17 cycles later.
REQ-028 Start A=6, B=9; during RUN drive start=1 with A=B=0xFFFF -> ignored, P=54, exactly one done pulse.
REQ-029 rst_n=0 at RUN iteration 8 of A=B=0x1234 -> busy=0, P=0, no done; a new start then gives 0x014B5A90.
REQ-030 With EARLY_TERM_EN, on the outputs:
- B=0x0001, A=0xABCD -> done in the cycle after E1, P=0xABCD
- B=0x0000 -> done in the cycle after E1, P=0
- B=0x8000 -> done in the cycle after E16
